// File: rtl/serial_mag_comp.sv
// Bit-serial N-bit unsigned magnitude comparator.
// The block takes operands over a valid/ready handshake. It feeds them MSB-first
// through a 1-bit mux comparator cell and stops at the first bit that differs.
// The eq/gr/less result is registered and offered over a second valid/ready handshake.
module serial_mag_comp #(
   parameter int unsigned N_BITS = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [N_BITS-1:0] i_a,
   input  logic [N_BITS-1:0] i_b,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_eq,
   output logic              o_gr,
   output logic              o_less,
   output logic              o_busy
);

   localparam int unsigned CntW = $clog2(N_BITS + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [N_BITS-1:0] r_a_sr;
   logic [N_BITS-1:0] r_b_sr;
   logic [CntW-1:0]   r_cnt;
   logic              r_eq;
   logic              r_gr;
   logic              r_less;

   logic w_bit_a;
   logic w_bit_b;
   logic w_cell_gr;
   logic w_cell_less;
   logic w_cell_eq;
   logic w_last_bit;

   // 1-bit mux comparator cell on the current MSBs
   always_comb begin
      w_bit_a     = r_a_sr[N_BITS-1];
      w_bit_b     = r_b_sr[N_BITS-1];
      w_cell_gr   = w_bit_a ? ~w_bit_b : 1'b0;
      w_cell_less = w_bit_b ? ~w_bit_a : 1'b0;
      w_cell_eq   = ~(w_cell_gr | w_cell_less);
      w_last_bit  = (r_cnt == CntW'(1));
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (i_in_valid) w_state_d = StShift;
         end
         StShift: begin
            // Leave on the first differing bit, or after the last bit if all matched
            if (!w_cell_eq || w_last_bit) w_state_d = StDone;
         end
         StDone: begin
            if (i_out_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and the result flags
   always_comb begin
      o_in_ready  = (r_state == StIdle);
      o_out_valid = (r_state == StDone);
      o_busy      = (r_state != StIdle);
      o_eq        = r_eq;
      o_gr        = r_gr;
      o_less      = r_less;
   end

   // Datapath: operand shift registers, bit counter and result flags
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a_sr <= '0;
         r_b_sr <= '0;
         r_cnt  <= '0;
         r_eq   <= 1'b0;
         r_gr   <= 1'b0;
         r_less <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_in_valid) begin
                  r_a_sr <= i_a;
                  r_b_sr <= i_b;
                  r_cnt  <= CntW'(N_BITS);
               end
            end
            StShift: begin
               r_a_sr <= r_a_sr << 1;
               r_b_sr <= r_b_sr << 1;
               r_cnt  <= r_cnt - CntW'(1);
               if (!w_cell_eq) begin
                  r_gr   <= w_cell_gr;
                  r_less <= w_cell_less;
                  r_eq   <= 1'b0;
               end else if (w_last_bit) begin
                  r_eq   <= 1'b1;
                  r_gr   <= 1'b0;
                  r_less <= 1'b0;
               end
            end
            StDone: begin
               // Flags are only meaningful while out_valid is high
               if (i_out_ready) begin
                  r_eq   <= 1'b0;
                  r_gr   <= 1'b0;
                  r_less <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp, with one 8-bit instance and one 1-bit instance.
module tb_serial_mag_comp;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       v8;
   logic       v1;
   logic       out_ready;

   logic ir8, ov8, eq8, gr8, ls8, bz8;
   logic ir1, ov1, eq1, gr1, ls1, bz1;

   int total = 0;
   int bad   = 0;
   bit sel   = 1'b0;

   always #5 clk = ~clk;

   serial_mag_comp #(.N_BITS(8)) u_dut8 (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_in_valid (v8),
      .o_in_ready (ir8),
      .i_a        (a),
      .i_b        (b),
      .o_out_valid(ov8),
      .i_out_ready(out_ready),
      .o_eq       (eq8),
      .o_gr       (gr8),
      .o_less     (ls8),
      .o_busy     (bz8)
   );

   serial_mag_comp #(.N_BITS(1)) u_dut1 (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_in_valid (v1),
      .o_in_ready (ir1),
      .i_a        (a[0:0]),
      .i_b        (b[0:0]),
      .o_out_valid(ov1),
      .i_out_ready(out_ready),
      .o_eq       (eq1),
      .o_gr       (gr1),
      .o_less     (ls1),
      .o_busy     (bz1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] flags();
      return sel ? {eq1, gr1, ls1} : {eq8, gr8, ls8};
   endfunction
   function automatic logic ov();
      return sel ? ov1 : ov8;
   endfunction
   function automatic logic ir();
      return sel ? ir1 : ir8;
   endfunction
   function automatic logic bz();
      return sel ? bz1 : bz8;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after the accept edge; counts edges until out_valid rises
   task automatic wait_valid(input string tag, input int exp_k);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!ov() && k < 20);
      if (!ov()) chk({tag, "_timeout"}, 32'd0, 32'd1);
      else       chk({tag, "_lat"}, k, exp_k);
   endtask

   // Single transaction with out_ready high; flags packed {eq,gr,less}
   task automatic run_op(input bit s, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] ef, input int ek, input string tag);
      sel       = s;
      a         = ia;
      b         = ib;
      out_ready = 1'b1;
      if (s) v1 = 1'b1;
      else   v8 = 1'b1;
      chk({tag, "_rdy"}, ir(), 1);
      step();
      v1 = 1'b0;
      v8 = 1'b0;
      chk({tag, "_busy"}, bz(), 1);
      wait_valid(tag, ek);
      chk({tag, "_res"}, flags(), ef);
      step();
      chk({tag, "_drain"}, {ir(), ov(), flags()}, 5'b10000);
   endtask

   logic [7:0] pa [3] = '{8'd3, 8'd9, 8'd7};
   logic [7:0] pb [3] = '{8'd5, 8'd2, 8'd7};
   logic [2:0] pf [3] = '{3'b001, 3'b010, 3'b100};
   int         pk [3] = '{6, 5, 8};

   initial begin
      #200000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; v8 = 1'b0; v1 = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      #2;
      sel = 1'b0;
      chk("rst8", {ir(), ov(), bz(), flags()}, 6'b100000);
      sel = 1'b1;
      chk("rst1", {ir(), ov(), bz(), flags()}, 6'b100000);
      step();
      step();
      rst = 1'b0;

      // Equal, MSB-difference, LSB-difference
      run_op(1'b0, 8'hA5, 8'hA5, 3'b100, 8, "eq_a5");
      run_op(1'b0, 8'h80, 8'h7F, 3'b010, 1, "gr_80");
      run_op(1'b0, 8'h12, 8'h13, 3'b001, 8, "ls_12");

      // Backpressure
      sel = 1'b0; out_ready = 1'b0; a = 8'h40; b = 8'h41; v8 = 1'b1;
      step();
      v8 = 1'b0;
      wait_valid("bp", 8);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold", {ov8, ls8, eq8, gr8, ir8}, 5'b11000);
      end
      out_ready = 1'b1;
      step();
      chk("bp_rel", {ir8, ov8, ls8}, 3'b100);

      // Back-to-back with in_valid held; operands scrambled while busy
      sel = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (!ir8 && n < 20) begin
            step();
            n++;
         end
         if (!ir8) chk("b2b_rdy_timeout", 32'd0, 32'd1);
         a = pa[i]; b = pb[i]; v8 = 1'b1;
         step();
         a = 8'hFF; b = 8'h00;
         if (i == 2) v8 = 1'b0;
         chk("b2b_busy", bz8, 1);
         wait_valid("b2b", pk[i]);
         chk("b2b_res", flags(), pf[i]);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         chk("b2b_nodup", {ov8, bz8}, 2'b00);
      end

      // Reset in the middle of a compare
      sel = 1'b0; a = 8'h01; b = 8'h02; v8 = 1'b1;
      step();
      v8 = 1'b0;
      step(); step(); step();
      chk("mid_busy", bz8, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst", {ir8, ov8, bz8, flags()}, 6'b100000);
      step();
      chk("mid_rst_hold", {ir8, ov8}, 2'b10);
      rst = 1'b0;
      run_op(1'b0, 8'hC3, 8'hC1, 3'b010, 7, "post_rst");

      // 1-bit instance, all four combinations
      run_op(1'b1, 8'h00, 8'h00, 3'b100, 1, "n1_00");
      run_op(1'b1, 8'h01, 8'h01, 3'b100, 1, "n1_11");
      run_op(1'b1, 8'h01, 8'h00, 3'b010, 1, "n1_10");
      run_op(1'b1, 8'h00, 8'h01, 3'b001, 1, "n1_01");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
